branch_resolve_queue: RTL and testbench
=======================================

// Module: branch_resolve_queue
// PURPOSE
//  Feedback-side partner to the decode-stage branch predictor. Queues every conditional
//  branch predicted at decode (pc, prediction, recovery target) in program order.
//  Retires the oldest entry when execute resolves it, then produces the predictor feedback
//  triple (valid/pc/prediction/outcome) and, on mispredict, a redirect plus wrong-path flush.
//  Sits between decode and execute, next to the hazard controller.
// PARAMETERS
//  DEPTH      4             queue entries, power of two, >=2
//  ADDR_W     `ADDR_WIDTH   pc/target width
// PORTS
//  clk                  in   1       clock, single domain
//  rst                  in   1       synchronous reset, active-high
//  i_dec_valid          in   1       predicted conditional branch leaving decode
//  i_dec_pc             in   ADDR_W  pc of that branch
//  i_dec_prediction     in   BranchOutcome  prediction given at decode
//  i_dec_recovery_tgt   in   ADDR_W  fetch target if prediction proves wrong
//  o_dec_ready          out  1       queue can accept (registered, = ~full)
//  i_ex_valid           in   1       execute resolves the oldest in-flight branch
//  i_ex_pc              in   ADDR_W  pc of resolved branch (checked against head)
//  i_ex_outcome         in   BranchOutcome  actual outcome
//  o_fb_valid           out  1       feedback to predictor, 1-cycle pulse
//  o_fb_pc              out  ADDR_W  pc of resolved branch
//  o_fb_prediction      out  BranchOutcome  stored prediction
//  o_fb_outcome         out  BranchOutcome  actual outcome
//  o_redirect_valid     out  1       mispredict: fetch must restart at o_redirect_tgt
//  o_redirect_tgt       out  ADDR_W  stored recovery target of mispredicted branch
//  o_flush              out  1       younger instructions are wrong-path; kill them
//  o_err                out  1       sticky protocol error
// BEHAVIOUR
//  Reset (rst=1 at clk edge): queue empty, rd/wr ptrs 0, o_dec_ready=1; o_fb_*, o_redirect_*,
//   o_flush, o_err = 0; FSM = NORMAL. Reset wins over every other input, including mid-flush.
//  Enqueue: i_dec_valid & o_dec_ready & state==NORMAL writes tail. i_dec_valid while full -> dropped,
//   o_err set. Occupancy counter is DEPTH+1 states wide (0..DEPTH); pointers wrap modulo DEPTH.
//  Resolve: i_ex_valid & ~empty pops head. Registered outputs, latency 1: next cycle o_fb_valid=1
//   with head pc/prediction and i_ex_outcome. Simultaneous enqueue+resolve when full: resolve pops,
//   enqueue dropped (ready is registered ~full, no combinational ready path).
//  i_ex_valid on empty queue: no feedback, o_err set. i_ex_pc != head pc: feedback still issued, o_err set.
//  Mispredict (head prediction != i_ex_outcome): next cycle o_redirect_valid=1, o_redirect_tgt=head
//   recovery target, o_flush=1, all entries discarded (empty), FSM -> FLUSH.
//  Enqueue in the resolve cycle of a mispredict is wrong-path and is discarded.
//  FSM: NORMAL -(mispredict resolved)-> FLUSH -(1 cycle)-> NORMAL. In FLUSH: i_dec_valid ignored,
//   o_dec_ready=0, i_ex_valid ignored (no error). Redirect/flush are 1-cycle pulses.
//  Correct prediction: feedback only, no redirect, no flush.
// CONFIGURATION
//  BRANCH_RESOLVE_STATS_EN defined: adds o_stat_branches[31:0] and o_stat_mispredicts[31:0],
//   incremented with each o_fb_valid / o_redirect_valid pulse, saturating at 32'hFFFF_FFFF,
//   cleared by rst.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  mips_core_pkg: BranchOutcome (existing); add branch_rq_entry_t {pc, prediction, recovery_tgt}
//   and enum branch_rq_state_t {BRQ_NORMAL, BRQ_FLUSH}.
//  Sub-module branch_rq_fifo: DEPTH-entry storage, push/pop/clear, full/empty, registered ready.
//  Top holds the FSM, compare, output registers and optional stats.
// TESTING
//  1 Reset then enqueue pc=0x100 pred=TAKEN; resolve TAKEN -> next cycle fb_valid=1, fb_pc=0x100,
//    redirect_valid=0, flush=0.
//  2 Enqueue pc=0x200 pred=NOT_TAKEN tgt=0x240; resolve TAKEN -> redirect_valid=1, tgt=0x240,
//    flush=1; following cycle dec_ready=0; queue empty afterwards.
//  3 Enqueue 4 branches (DEPTH=4) -> dec_ready=0; 5th i_dec_valid -> o_err=1; resolve all four
//    -> fb_pc in order, ptrs wrap, dec_ready=1.
//  4 Full queue, enqueue+correct resolve same cycle -> one pop, enqueue dropped, occupancy=3.
//  5 i_ex_valid on empty queue -> no fb_valid, o_err=1 sticky until rst.
//  6 rst asserted during FLUSH -> next cycle all outputs 0, dec_ready=1, stats (if enabled) 0.

Source files
------------

// File: rtl/mips_core_pkg.sv
// mips_core_pkg: shared core types for the branch resolve queue.
//  BranchOutcome        - predicted/actual direction of a conditional branch
//  branch_rq_entry_t    - one in-flight branch: pc, prediction, recovery target
//  branch_rq_state_t    - resolve-queue FSM states (NORMAL, FLUSH)
//  `ADDR_WIDTH          - pc/target width, defaults to 32 when not set by the build
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

package mips_core_pkg;

  typedef enum logic {
    NOT_TAKEN = 1'b0,
    TAKEN     = 1'b1
  } BranchOutcome;

  typedef struct packed {
    logic [`ADDR_WIDTH-1:0] pc;
    BranchOutcome           prediction;
    logic [`ADDR_WIDTH-1:0] recovery_tgt;
  } branch_rq_entry_t;

  typedef enum logic {
    BRQ_NORMAL = 1'b0,
    BRQ_FLUSH  = 1'b1
  } branch_rq_state_t;

endpackage

// File: rtl/branch_resolve_queue_fifo.sv
// branch_rq_fifo: in-order storage for predicted branches awaiting resolution.
// Ports:
//  clk, rst      clock, synchronous active-high reset
//  push, wdata   write tail (ignored unless ready is high)
//  pop           advance head
//  clear         discard every entry (wins over push/pop)
//  rdata         current head entry
//  empty         no entries held
//  ready         registered ~full, valid for the current cycle
//  count         occupancy 0..DEPTH
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module branch_rq_fifo
  import mips_core_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  branch_rq_entry_t           wdata,
  input  logic                       pop,
  input  logic                       clear,
  output branch_rq_entry_t           rdata,
  output logic                       empty,
  output logic                       ready,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  branch_rq_entry_t   mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   count_next;
  logic               ready_q;
  logic               do_push;
  logic               do_pop;

  assign do_push = push & ready_q & ~clear;
  assign do_pop  = pop & (count_q != '0) & ~clear;

  always_comb begin
    count_next = count_q;
    if (clear) begin
      count_next = '0;
    end else begin
      case ({do_push, do_pop})
        2'b10:   count_next = count_q + 1'b1;
        2'b01:   count_next = count_q - 1'b1;
        default: count_next = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
    end else begin
      if (clear) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_next;
      // Ready is computed from next occupancy so it never depends
      // combinationally on this cycle's push/pop inputs downstream.
      ready_q <= (count_next != CNT_W'(DEPTH));
    end
  end

  // Storage needs no reset: entries are only read when count says valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

  assign rdata = mem[rd_ptr_q];
  assign empty = (count_q == '0);
  assign ready = ready_q;
  assign count = count_q;

endmodule

// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: queues decode-stage branch predictions in program
// order, retires the oldest when execute resolves it, and emits predictor
// feedback plus, on a mispredict, a fetch redirect and wrong-path flush.
// Ports:
//  clk, rst                 clock, synchronous active-high reset
//  i_dec_*                  predicted branch from decode (pc, prediction, recovery target)
//  o_dec_ready              queue accepts this cycle (registered)
//  i_ex_*                   resolution of the oldest branch (pc, outcome)
//  o_fb_*                   predictor feedback, o_fb_valid is a 1-cycle pulse
//  o_redirect_valid/_tgt    restart fetch at the stored recovery target
//  o_flush                  kill wrong-path younger instructions
//  o_err                    sticky protocol error (overflow, empty resolve, pc mismatch)
//  o_dbg_state              FSM state (0 NORMAL, 1 FLUSH)
//  o_dbg_count              queue occupancy
//  o_stat_branches/_mispredicts  saturating counters, only with BRANCH_RESOLVE_STATS_EN
// Handshake: a decode branch transfers on a clock edge where i_dec_valid and
// o_dec_ready are both high; o_dec_ready comes from registers only, so a
// valid while not ready is a dropped branch (flagged on o_err). i_ex_valid
// has no ready: execute may resolve whenever a branch is in flight.
// Build option: define BRANCH_RESOLVE_STATS_EN to add the statistics counters.
module branch_resolve_queue
  import mips_core_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = `ADDR_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_dec_valid,
  input  logic [ADDR_W-1:0]      i_dec_pc,
  input  BranchOutcome           i_dec_prediction,
  input  logic [ADDR_W-1:0]      i_dec_recovery_tgt,
  output logic                   o_dec_ready,
  input  logic                   i_ex_valid,
  input  logic [ADDR_W-1:0]      i_ex_pc,
  input  BranchOutcome           i_ex_outcome,
  output logic                   o_fb_valid,
  output logic [ADDR_W-1:0]      o_fb_pc,
  output BranchOutcome           o_fb_prediction,
  output BranchOutcome           o_fb_outcome,
  output logic                   o_redirect_valid,
  output logic [ADDR_W-1:0]      o_redirect_tgt,
  output logic                   o_flush,
  output logic                   o_err,
  output logic                   o_dbg_state,
  output logic [$clog2(DEPTH):0] o_dbg_count
`ifdef BRANCH_RESOLVE_STATS_EN
  ,
  output logic [31:0]            o_stat_branches,
  output logic [31:0]            o_stat_mispredicts
`endif
);

  branch_rq_state_t  state_q;
  branch_rq_entry_t  wr_entry;
  branch_rq_entry_t  head;
  logic              fifo_empty;
  logic              fifo_ready;
  logic              in_normal;
  logic              resolve;
  logic              mispredict;
  logic              push;
  logic              pop;
  logic              err_event;

  assign wr_entry.pc           = i_dec_pc;
  assign wr_entry.prediction   = i_dec_prediction;
  assign wr_entry.recovery_tgt = i_dec_recovery_tgt;

  always_comb begin
    in_normal  = (state_q == BRQ_NORMAL);
    resolve    = in_normal & i_ex_valid & ~fifo_empty;
    mispredict = resolve & (head.prediction != i_ex_outcome);
    // A branch arriving in the same cycle a mispredict resolves is on the
    // wrong path, so it is not written.
    push       = in_normal & i_dec_valid & fifo_ready & ~mispredict;
    pop        = resolve & ~mispredict;
    // During FLUSH both request inputs are ignored without raising errors.
    err_event  = in_normal & ((i_dec_valid & ~fifo_ready)
                            | (i_ex_valid & fifo_empty)
                            | (resolve & (i_ex_pc != head.pc)));
  end

  branch_rq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wr_entry),
    .pop   (pop),
    .clear (mispredict),
    .rdata (head),
    .empty (fifo_empty),
    .ready (fifo_ready),
    .count (o_dbg_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= BRQ_NORMAL;
      o_fb_valid       <= 1'b0;
      o_fb_pc          <= '0;
      o_fb_prediction  <= NOT_TAKEN;
      o_fb_outcome     <= NOT_TAKEN;
      o_redirect_valid <= 1'b0;
      o_redirect_tgt   <= '0;
      o_flush          <= 1'b0;
      o_err            <= 1'b0;
    end else begin
      o_fb_valid       <= resolve;
      o_redirect_valid <= mispredict;
      o_flush          <= mispredict;
      o_err            <= o_err | err_event;
      if (resolve) begin
        o_fb_pc         <= head.pc;
        o_fb_prediction <= head.prediction;
        o_fb_outcome    <= i_ex_outcome;
      end
      if (mispredict) o_redirect_tgt <= head.recovery_tgt;
      case (state_q)
        BRQ_NORMAL: if (mispredict) state_q <= BRQ_FLUSH;
        BRQ_FLUSH:  state_q <= BRQ_NORMAL;
        default:    state_q <= BRQ_NORMAL;
      endcase
    end
  end

  // Ready is the FIFO's registered ~full, held low for the flush cycle.
  assign o_dec_ready = fifo_ready & in_normal;
  assign o_dbg_state = (state_q == BRQ_FLUSH);

`ifdef BRANCH_RESOLVE_STATS_EN
  // Counters advance on the edge that raises the matching pulse, so they
  // already include that pulse while it is visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_stat_branches    <= '0;
      o_stat_mispredicts <= '0;
    end else begin
      if (resolve && (o_stat_branches != 32'hFFFF_FFFF))
        o_stat_branches <= o_stat_branches + 32'd1;
      if (mispredict && (o_stat_mispredicts != 32'hFFFF_FFFF))
        o_stat_mispredicts <= o_stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
module tb_branch_resolve_queue;
  import mips_core_pkg::*;

  localparam int DEPTH = 4;
  localparam int W     = 68;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          i_dec_valid = 1'b0;
  logic [31:0]   i_dec_pc = '0;
  BranchOutcome  i_dec_prediction = NOT_TAKEN;
  logic [31:0]   i_dec_recovery_tgt = '0;
  logic          o_dec_ready;
  logic          i_ex_valid = 1'b0;
  logic [31:0]   i_ex_pc = '0;
  BranchOutcome  i_ex_outcome = NOT_TAKEN;
  logic          o_fb_valid;
  logic [31:0]   o_fb_pc;
  BranchOutcome  o_fb_prediction;
  BranchOutcome  o_fb_outcome;
  logic          o_redirect_valid;
  logic [31:0]   o_redirect_tgt;
  logic          o_flush;
  logic          o_err;
  logic          o_dbg_state;
  logic [2:0]    o_dbg_count;
`ifdef BRANCH_RESOLVE_STATS_EN
  logic [31:0]   o_stat_branches;
  logic [31:0]   o_stat_mispredicts;
`endif

  branch_resolve_queue #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
    .clk                (clk),
    .rst                (rst),
    .i_dec_valid        (i_dec_valid),
    .i_dec_pc           (i_dec_pc),
    .i_dec_prediction   (i_dec_prediction),
    .i_dec_recovery_tgt (i_dec_recovery_tgt),
    .o_dec_ready        (o_dec_ready),
    .i_ex_valid         (i_ex_valid),
    .i_ex_pc            (i_ex_pc),
    .i_ex_outcome       (i_ex_outcome),
    .o_fb_valid         (o_fb_valid),
    .o_fb_pc            (o_fb_pc),
    .o_fb_prediction    (o_fb_prediction),
    .o_fb_outcome       (o_fb_outcome),
    .o_redirect_valid   (o_redirect_valid),
    .o_redirect_tgt     (o_redirect_tgt),
    .o_flush            (o_flush),
    .o_err              (o_err),
    .o_dbg_state        (o_dbg_state),
    .o_dbg_count        (o_dbg_count)
`ifdef BRANCH_RESOLVE_STATS_EN
    ,
    .o_stat_branches    (o_stat_branches),
    .o_stat_mispredicts (o_stat_mispredicts)
`endif
  );

  // ---------------- scoreboard and reference model ----------------
  // exp_q word: {pc, prediction, outcome, redirect, flush, redirect_tgt or 0}
  logic [W-1:0] exp_q[$];
  // model queue entry: {pc[64:33], prediction[32], tgt[31:0]}
  logic [64:0]  mq[$];
  logic         m_flush = 1'b0;
  logic         m_err   = 1'b0;
  logic         m_ready = 1'b1;
  logic [31:0]  m_br    = '0;
  logic [31:0]  m_mis   = '0;
  int           n_pass  = 0;
  int           n_total = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // ---------------- driver ----------------
  // Drive one cycle of inputs, advance the model, then check outputs #1
  // after the clock edge.
  task automatic step(input logic dv, input logic [31:0] dpc, input logic dpred,
                      input logic [31:0] dtgt, input logic ev, input logic [31:0] epc,
                      input logic eout);
    logic        res;
    logic        misp;
    logic [64:0] hd;
    logic [W-1:0] e;
    logic [W-1:0] o;
    i_dec_valid        = dv;
    i_dec_pc           = dpc;
    i_dec_prediction   = BranchOutcome'(dpred);
    i_dec_recovery_tgt = dtgt;
    i_ex_valid         = ev;
    i_ex_pc            = epc;
    i_ex_outcome       = BranchOutcome'(eout);
    res  = 1'b0;
    misp = 1'b0;
    if (rst) begin
      mq.delete();
      exp_q.delete();
      m_flush = 1'b0;
      m_err   = 1'b0;
      m_br    = '0;
      m_mis   = '0;
    end else if (m_flush) begin
      m_flush = 1'b0;
    end else begin
      if (ev && mq.size() == 0) m_err = 1'b1;
      if (ev && mq.size() > 0) begin
        res  = 1'b1;
        hd   = mq[0];
        misp = (hd[32] != eout);
        if (epc != hd[64:33]) m_err = 1'b1;
        exp_q.push_back({hd[64:33], hd[32], eout, misp, misp, misp ? hd[31:0] : 32'h0});
        if (m_br != 32'hFFFF_FFFF) m_br = m_br + 1;
        if (misp && m_mis != 32'hFFFF_FFFF) m_mis = m_mis + 1;
      end
      if (dv && !m_ready) m_err = 1'b1;
      if (misp) begin
        mq.delete();
        m_flush = 1'b1;
      end else begin
        if (res) void'(mq.pop_front());
        if (dv && m_ready) mq.push_back({dpc, dpred, dtgt});
      end
    end
    m_ready = !m_flush && (mq.size() < DEPTH);

    @(posedge clk);
    #1;
    if (o_fb_valid) begin
      o = {o_fb_pc, o_fb_prediction, o_fb_outcome, o_redirect_valid, o_flush,
           o_redirect_valid ? o_redirect_tgt : 32'h0};
      if (exp_q.size() == 0) check("fb_unexpected", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("fb_result", o, e);
      end
    end else begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("fb_missing", 0, 1);
      end
      check("no_redirect", {o_redirect_valid, o_flush}, 2'b00);
    end
    check("dec_ready", o_dec_ready, m_ready);
    check("err", o_err, m_err);
    check("state", o_dbg_state, m_flush);
    check("count", o_dbg_count, mq.size());
`ifdef BRANCH_RESOLVE_STATS_EN
    check("stat_br", o_stat_branches, m_br);
    check("stat_mis", o_stat_mispredicts, m_mis);
`endif
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic enq(input logic [31:0] pc, input logic pred, input logic [31:0] tgt);
    step(1, pc, pred, tgt, 0, 0, 0);
  endtask

  task automatic res(input logic [31:0] pc, input logic outc);
    step(0, 0, 0, 0, 1, pc, outc);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    check("rst_fb_pc", o_fb_pc, 0);
    check("rst_redir_tgt", o_redirect_tgt, 0);
    check("rst_fb_valid", o_fb_valid, 0);
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] pc;
    logic        p;
    do_reset();
    idle();

    // 1: correct prediction -> feedback only
    enq(32'h100, 1, 32'h180);
    res(32'h100, 1);
    idle();

    // 2: mispredict -> redirect + flush, then FLUSH cycle ignores requests
    enq(32'h200, 0, 32'h240);
    res(32'h200, 1);
    step(1, 32'h2F0, 1, 0, 1, 32'h200, 1);
    idle();

    // 3: fill, overflow, drain in order
    for (int i = 0; i < DEPTH; i++) enq(32'h300 + i * 4, i[0], 32'h900 + i * 4);
    enq(32'h3F0, 0, 0);
    for (int i = 0; i < DEPTH; i++) res(32'h300 + i * 4, i[0]);
    idle();

    // 4: full queue, enqueue + correct resolve same cycle
    do_reset();
    for (int i = 0; i < DEPTH; i++) enq(32'h400 + i * 4, 1, 32'hA00);
    step(1, 32'h4F0, 1, 0, 1, 32'h400, 1);
    for (int i = 1; i < DEPTH; i++) res(32'h400 + i * 4, 1);
    idle();

    // 5: resolve on empty queue -> sticky error, no feedback
    do_reset();
    res(32'h500, 1);
    idle();
    idle();
    enq(32'h510, 0, 0);
    res(32'h514, 0);

    // 6: reset during FLUSH
    enq(32'h600, 1, 32'h640);
    res(32'h600, 0);
    do_reset();
    idle();

    // random traffic
    for (int n = 0; n < 300; n++) begin
      pc = $urandom_range(0, 32'hFFFF) << 2;
      p  = $urandom_range(0, 1);
      if (mq.size() > 0 && $urandom_range(0, 15) != 0)
        step($urandom_range(0, 1), pc, p, pc + 32'h40, $urandom_range(0, 2) == 0,
             mq[0][64:33], ($urandom_range(0, 3) == 0) ? ~mq[0][32] : mq[0][32]);
      else
        step($urandom_range(0, 1), pc, p, pc + 32'h40, $urandom_range(0, 5) == 0,
             pc, $urandom_range(0, 1));
    end
    idle();
    idle();
    check("sb_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
